fp_sqrt_issue_ctrl: RTL and testbench

FP_SQRT_ISSUE_CTRL -- requirements
Module: fp_sqrt_issue_ctrl

---
 rtl/fp_sqrt_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fp_sqrt_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_issue_ctrl.sv
// Issue controller for a fixed-latency single-precision square-root datapath.
// Specials resolve locally; optional sticky flags are enabled by FP_SQRT_STICKY_FLAGS_EN.
module fp_sqrt_issue_ctrl #(
  parameter int unsigned LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_invalid,
  output logic        out_underflow,
  output logic [31:0] sqrt_a,
  output logic        sqrt_en,
  input  logic [31:0] sqrt_result,
  output logic        busy,
`ifdef FP_SQRT_STICKY_FLAGS_EN
  input  logic        flag_clr,
  output logic        sticky_invalid,
  output logic        sticky_underflow,
`endif
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the
  // result/flags stay frozen until out_ready is seen there.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] PINF     = 32'h7F80_0000;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] sqrt_a_q, sqrt_a_d;
  logic [31:0] res_q, res_d;
  logic        inv_q, inv_d;
  logic        unf_q, unf_d;
  logic        live_q;

  logic [7:0]  op_exp;
  logic [22:0] op_man;
  logic        op_normal;
  logic [31:0] spec_res;
  logic        spec_inv;
  logic        spec_unf;
  logic        accept;

  // Operand classification; zero and denormal share the signed-zero result.
  always_comb begin
    op_exp    = in_a[30:23];
    op_man    = in_a[22:0];
    op_normal = 1'b0;
    spec_res  = 32'h0;
    spec_inv  = 1'b0;
    spec_unf  = 1'b0;
    if (op_exp == 8'hFF && op_man != 23'h0) begin
      spec_res = in_a | 32'h0040_0000;
      spec_inv = ~in_a[22];
    end else if (op_exp == 8'h00) begin
      spec_res = {in_a[31], 31'h0};
      spec_unf = (op_man != 23'h0);
    end else if (in_a[31]) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (op_exp == 8'hFF) begin
      spec_res = PINF;
    end else begin
      op_normal = 1'b1;
    end
  end

  assign in_ready  = (state_q == IDLE) && live_q;
  assign busy      = (state_q != IDLE);
  assign sqrt_en   = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sqrt_a_d = sqrt_a_q;
    res_d    = res_q;
    inv_d    = inv_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_normal) begin
            state_d  = BUSY;
            cnt_d    = CNT_INIT;
            sqrt_a_d = in_a;
          end else begin
            state_d = DONE;
            res_d   = spec_res;
            inv_d   = spec_inv;
            unf_d   = spec_unf;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 8'h0) begin
          state_d = DONE;
          res_d   = sqrt_result;
          inv_d   = 1'b0;
          unf_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'h1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // live_q holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'h0;
      sqrt_a_q <= 32'h0;
      res_q    <= 32'h0;
      inv_q    <= 1'b0;
      unf_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sqrt_a_q <= sqrt_a_d;
      res_q    <= res_d;
      inv_q    <= inv_d;
      unf_q    <= unf_d;
      live_q   <= 1'b1;
    end
  end

  assign sqrt_a        = sqrt_a_q;
  assign out_result    = res_q;
  assign out_invalid   = inv_q;
  assign out_underflow = unf_q;
  assign state_dbg     = state_q;

`ifdef FP_SQRT_STICKY_FLAGS_EN
  logic sticky_inv_q, sticky_inv_d;
  logic sticky_unf_q, sticky_unf_d;
  logic out_hs;

  // A setting handshake beats a simultaneous clear.
  always_comb begin
    out_hs       = out_valid && out_ready;
    sticky_inv_d = sticky_inv_q;
    sticky_unf_d = sticky_unf_q;
    if (flag_clr) begin
      sticky_inv_d = 1'b0;
      sticky_unf_d = 1'b0;
    end
    if (out_hs && inv_q) sticky_inv_d = 1'b1;
    if (out_hs && unf_q) sticky_unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_inv_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_inv_q <= sticky_inv_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign sticky_invalid   = sticky_inv_q;
  assign sticky_underflow = sticky_unf_q;
`endif

endmodule

// File: tb/tb_fp_sqrt_issue_ctrl.sv
// Self-checking bench for fp_sqrt_issue_ctrl: fixed-latency datapath model,
// expected-result queue checked at each output handshake.
module tb_fp_sqrt_issue_ctrl;

  localparam int LAT = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_invalid;
  logic        out_underflow;
  logic [31:0] sqrt_a;
  logic        sqrt_en;
  logic [31:0] sqrt_result;
  logic        busy;
  logic        flag_clr;
  logic        sticky_invalid;
  logic        sticky_underflow;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];

  fp_sqrt_issue_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_invalid(out_invalid), .out_underflow(out_underflow),
    .sqrt_a(sqrt_a), .sqrt_en(sqrt_en), .sqrt_result(sqrt_result),
    .busy(busy),
`ifdef FP_SQRT_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .sticky_invalid(sticky_invalid),
    .sticky_underflow(sticky_underflow),
`endif
    .state_dbg(state_dbg)
  );

`ifndef FP_SQRT_STICKY_FLAGS_EN
  assign sticky_invalid   = 1'b0;
  assign sticky_underflow = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- datapath model ----------------
  function automatic logic [31:0] dp_func(input logic [31:0] a);
    case (a)
      32'h4080_0000: return 32'h4000_0000;  // 4 -> 2
      32'h4110_0000: return 32'h4040_0000;  // 9 -> 3
      32'h3F80_0000: return 32'h3F80_0000;  // 1 -> 1
      32'h42C8_0000: return 32'h4120_0000;  // 100 -> 10
      default:       return a ^ 32'h1234_5678;
    endcase
  endfunction

  // The result is only meaningful in the last cycle of a LAT-long enable run.
  int en_cnt = 0;
  always @(posedge clk) en_cnt <= sqrt_en ? en_cnt + 1 : 0;
  assign sqrt_result = (sqrt_en && en_cnt == LAT - 1) ? dp_func(sqrt_a) : 32'hDEAD_BEEF;

  // {normal, invalid, underflow, result}
  function automatic logic [34:0] model(input logic [31:0] a);
    logic [7:0]  e;
    logic [22:0] m;
    e = a[30:23];
    m = a[22:0];
    if (e == 8'hFF && m != 0) return {1'b0, ~a[22], 1'b0, a | 32'h0040_0000};
    if (e == 8'h00 && m == 0) return {3'b000, a};
    if (e == 8'h00)           return {3'b001, a[31], 31'h0};
    if (a[31])                return {3'b010, 32'h7FC0_0000};
    if (e == 8'hFF)           return {3'b000, 32'h7F80_0000};
    return {3'b100, dp_func(a)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_result), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("out_result", 64'(out_result), 64'(e[31:0]));
        check("out_flags", 64'({out_invalid, out_underflow}), 64'(e[33:32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one operand, checks latency, enable count and operand hold.
  // With hold=1 it returns at the first DONE cycle without a handshake.
  task automatic send(input logic [31:0] a, input bit hold);
    logic [34:0] m;
    int wt, lat, en_cyc, a_bad;
    out_ready = !hold;
    wt = 0;
    while (!in_ready && wt < 50) begin
      tick();
      wt++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    m = model(a);
    in_valid = 1'b1;
    in_a     = a;
    @(posedge clk);
    exp_q.push_back(m[33:0]);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    lat = 1; en_cyc = 0; a_bad = 0;
    while (lat < 300) begin
      @(negedge clk);
      if (sqrt_en) begin
        en_cyc++;
        if (sqrt_a !== a) a_bad++;
      end
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), m[34] ? 64'(LAT + 1) : 64'd1);
    check("sqrt_en_cycles", 64'(en_cyc), m[34] ? 64'(LAT) : 64'd0);
    if (m[34]) check("sqrt_a_hold", 64'(a_bad), 64'd0);
    if (!hold) begin
      tick();
      check("idle_after_hs", 64'({out_valid, in_ready, state_dbg}), 64'b0100);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 32'h0; out_ready = 1'b1; flag_clr = 1'b0;
    #23;
    check("reset_outs", 64'({out_valid, out_invalid, out_underflow, sqrt_en, busy, in_ready}), 64'd0);
    check("reset_data", {out_result, sqrt_a}, 64'd0);
    check("reset_sticky", 64'({sticky_invalid, sticky_underflow}), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 64'(in_ready), 64'd0);
    tick();
    check("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Directed operands: normal, negative, zeros, denormal, inf, NaNs.
    send(32'h4080_0000, 0);
    send(32'hBF80_0000, 0);
    send(32'h8000_0000, 0);
    send(32'h0000_0001, 0);
    send(32'h0000_0000, 0);
    send(32'h807F_FFFF, 0);
    send(32'h7F80_0000, 0);
    send(32'hFF80_0000, 0);
    send(32'h7F80_0001, 0);
    send(32'h7FC0_0001, 0);
    send(32'hFF80_0123, 0);
    send(32'h3F80_0000, 0);
    send(32'h42C8_0000, 0);

    // Random normals and random bit patterns.
    for (int i = 0; i < 12; i++) begin
      send({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 0);
      send($urandom, 0);
    end

    // Output stall: result frozen, input ignored, then handshake.
    send(32'h4110_0000, 1);
    in_valid = 1'b1;
    in_a     = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 64'({out_valid, in_ready, state_dbg}), 64'b1010);
      check("stall_result", 64'(out_result), 64'h4040_0000);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release", 64'({out_valid, in_ready, state_dbg}), 64'b0100);
    check("stall_no_extra", 64'(exp_q.size()), 64'd0);

    // Reset in the third BUSY cycle aborts the operation.
    in_valid = 1'b1;
    in_a     = 32'h4080_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    tick();
    check("busy_before_abort", 64'(state_dbg), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", 64'({out_valid, out_invalid, out_underflow, sqrt_en, busy, in_ready, state_dbg}), 64'd0);
    check("abort_data", {out_result, sqrt_a}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("abort_in_ready_low", 64'(in_ready), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_output", 64'(seen), 64'd0);
    end
    #1;
    send(32'h4080_0000, 0);

`ifdef FP_SQRT_STICKY_FLAGS_EN
    send(32'hBF80_0000, 0);
    check("sticky_inv_set", 64'({sticky_invalid, sticky_underflow}), 64'b10);
    send(32'h0000_0001, 0);
    check("sticky_unf_set", 64'({sticky_invalid, sticky_underflow}), 64'b11);
    send(32'hFF80_0000, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    flag_clr  = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("sticky_set_wins", 64'({sticky_invalid, sticky_underflow}), 64'b10);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("sticky_cleared", 64'({sticky_invalid, sticky_underflow}), 64'b00);
`endif

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
